// File: rtl/motoro3_pkg.sv
// Shared types and helpers for the motoro3 open-loop speed-ramp scheduler.
// Holds the FSM state encoding, the period width and the period clamp.
package motoro3_pkg;

    localparam int PW = 25;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SLEW  = 3'd1,
        RUN   = 3'd2,
        STOP  = 3'd3,
        FAULT = 3'd4
    } state_t;

    function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p,
                                                   input logic [PW-1:0] lo,
                                                   input logic [PW-1:0] hi);
        if (p < lo)
            return lo;
        else if (p > hi)
            return hi;
        else
            return p;
    endfunction

endpackage

// File: rtl/motoro3_ramp_scheduler_if.sv
// Host/step-generator facing bundle of the ramp scheduler.
// master = host plus step generator side, slave = the scheduler.
interface motoro3_ramp_scheduler_if;
    import motoro3_pkg::*;

    logic          run_req;
    logic [PW-1:0] target_period;
    logic          step_tick;
    logic          fault_in;
    logic          fault_clr;
    logic          m3start;
    logic [PW-1:0] step_period;
    state_t        state;
    logic          at_speed;
    logic          fault;
    logic [15:0]   step_cnt;

    modport master (
        output run_req, target_period, step_tick, fault_in, fault_clr,
        input  m3start, step_period, state, at_speed, fault, step_cnt
    );

    modport slave (
        input  run_req, target_period, step_tick, fault_in, fault_clr,
        output m3start, step_period, state, at_speed, fault, step_cnt
    );

endinterface

// File: rtl/motoro3_step_watchdog.sv
// Stalled-generator watchdog: counts cycles between commutation steps while
// the generator is enabled and flags a timeout when the limit is reached.
module motoro3_step_watchdog #(
    parameter int unsigned WDOG_CYCLES = 4_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic step_tick,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(WDOG_CYCLES);

    logic [CW-1:0] cnt;

    // Counter saturates at the limit so timeout stays asserted until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!enable || step_tick)
            cnt <= '0;
        else if (cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    assign timeout = enable && (cnt == LIMIT);

endmodule

// File: rtl/motoro3_ramp_scheduler.sv
// Open-loop speed-ramp controller for the 3-phase commutation step generator.
// Optional stall watchdog enabled by MOTORO3_RAMP_WATCHDOG_EN.
module motoro3_ramp_scheduler
    import motoro3_pkg::*;
#(
    parameter logic [PW-1:0] START_PERIOD = 25'd1_666_667,
    parameter logic [PW-1:0] MIN_PERIOD   = 25'd16_667,
    parameter logic [PW-1:0] STEP_DELTA   = 25'd16_667,
    parameter int unsigned   WDOG_CYCLES  = 4_000_000
) (
    input logic                      clk,
    input logic                      rst,
    motoro3_ramp_scheduler_if.slave  bus
);

    state_t        state;
    logic          m3start;
    logic [PW-1:0] step_period;
    logic          at_speed;
    logic          fault;
    logic [15:0]   step_cnt;

    logic [PW-1:0] tgt;
    logic [PW:0]   up_sum;
    logic [PW:0]   dn_floor;
    logic [PW-1:0] slew_next;
    logic [PW-1:0] stop_next;
    logic          wdog_timeout;
    logic          fault_evt;

`ifdef MOTORO3_RAMP_WATCHDOG_EN
    motoro3_step_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .step_tick (bus.step_tick),
        .enable    (m3start),
        .timeout   (wdog_timeout)
    );
`else
    wire unused_wdog_cfg = ^WDOG_CYCLES;
    assign wdog_timeout = 1'b0;
`endif

    // Slew arithmetic runs one bit wide so neither step can wrap.
    always_comb begin
        tgt       = clamp_period(bus.target_period, MIN_PERIOD, START_PERIOD);
        up_sum    = {1'b0, step_period} + {1'b0, STEP_DELTA};
        dn_floor  = {1'b0, tgt} + {1'b0, STEP_DELTA};
        slew_next = tgt;
        if (step_period > tgt) begin
            if ({1'b0, step_period} >= dn_floor)
                slew_next = step_period - STEP_DELTA;
        end else if (step_period < tgt) begin
            if (up_sum < {1'b0, tgt})
                slew_next = up_sum[PW-1:0];
        end
        stop_next = (up_sum >= {1'b0, START_PERIOD}) ? START_PERIOD : up_sum[PW-1:0];
    end

    assign fault_evt = (bus.fault_in || wdog_timeout) && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            m3start     <= 1'b0;
            step_period <= START_PERIOD;
            at_speed    <= 1'b0;
            fault       <= 1'b0;
            step_cnt    <= '0;
        end else if (fault_evt) begin
            state       <= FAULT;
            m3start     <= 1'b0;
            step_period <= START_PERIOD;
            at_speed    <= 1'b0;
            fault       <= 1'b0 | 1'b1;
        end else begin
            if (m3start && bus.step_tick)
                step_cnt <= step_cnt + 16'd1;
            unique case (state)
                IDLE: begin
                    if (bus.run_req) begin
                        state       <= SLEW;
                        m3start     <= 1'b1;
                        step_period <= START_PERIOD;
                        step_cnt    <= '0;
                    end
                end
                SLEW: begin
                    if (!bus.run_req) begin
                        state <= STOP;
                    end else if (bus.step_tick) begin
                        step_period <= slew_next;
                        if (slew_next == tgt) begin
                            state    <= RUN;
                            at_speed <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A tick coinciding with the stop request does not move the period.
                    if (!bus.run_req) begin
                        state    <= STOP;
                        at_speed <= 1'b0;
                    end else if (tgt != step_period) begin
                        state    <= SLEW;
                        at_speed <= 1'b0;
                    end
                end
                STOP: begin
                    if (bus.run_req) begin
                        state <= SLEW;
                    end else if (bus.step_tick) begin
                        if (step_period == START_PERIOD) begin
                            state   <= IDLE;
                            m3start <= 1'b0;
                        end else begin
                            step_period <= stop_next;
                        end
                    end
                end
                FAULT: begin
                    if (bus.fault_clr && !bus.run_req) begin
                        state <= IDLE;
                        fault <= 1'b0;
                    end
                end
                default: begin
                    state   <= FAULT;
                    m3start <= 1'b0;
                    fault   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.state       = state;
    assign bus.m3start     = m3start;
    assign bus.step_period = step_period;
    assign bus.at_speed    = at_speed;
    assign bus.fault       = fault;
    assign bus.step_cnt    = step_cnt;

endmodule

// File: tb/tb_motoro3_ramp_scheduler.sv
// Directed bench for motoro3_ramp_scheduler with START=1000, MIN=100, DELTA=300.
// Expected values are hand-computed ramp sequences.
module tb_motoro3_ramp_scheduler;
    import motoro3_pkg::*;

    localparam logic [PW-1:0] START = 25'd1000;
    localparam logic [PW-1:0] MINP  = 25'd100;
    localparam logic [PW-1:0] DELTA = 25'd300;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    motoro3_ramp_scheduler_if bus ();

    motoro3_ramp_scheduler #(
        .START_PERIOD (START),
        .MIN_PERIOD   (MINP),
        .STEP_DELTA   (DELTA),
        .WDOG_CYCLES  (500)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One step_tick pulse, preceded by 49 quiet cycles (tick every 50 clk).
    task automatic tick();
        cyc(49);
        bus.step_tick = 1'b1;
        cyc(1);
        bus.step_tick = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.run_req       = 1'b0;
        bus.target_period = 25'd200;
        bus.step_tick     = 1'b0;
        bus.fault_in      = 1'b0;
        bus.fault_clr     = 1'b0;
        cyc(3);
        chk("rst_state",    32'(bus.state), 32'(IDLE));
        chk("rst_m3start",  32'(bus.m3start), 0);
        chk("rst_period",   32'(bus.step_period), 1000);
        chk("rst_at_speed", 32'(bus.at_speed), 0);
        chk("rst_fault",    32'(bus.fault), 0);
        chk("rst_step_cnt", 32'(bus.step_cnt), 0);
        rst = 1'b0;
        cyc(2);

        // Start ramp to 200
        bus.run_req = 1'b1;
        cyc(1);
        chk("start_m3start", 32'(bus.m3start), 1);
        chk("start_state",   32'(bus.state), 32'(SLEW));
        chk("start_period",  32'(bus.step_period), 1000);
        tick(); chk("ramp_t1", 32'(bus.step_period), 700);
        tick(); chk("ramp_t2", 32'(bus.step_period), 400);
        chk("ramp_t2_state", 32'(bus.state), 32'(SLEW));
        tick(); chk("ramp_t3", 32'(bus.step_period), 200);
        chk("ramp_run",      32'(bus.state), 32'(RUN));
        chk("ramp_at_speed", 32'(bus.at_speed), 1);
        chk("ramp_cnt",      32'(bus.step_cnt), 3);

        // Clamp low: target 10 -> 100
        bus.target_period = 25'd10;
        cyc(1);
        chk("clamp_lo_slew", 32'(bus.state), 32'(SLEW));
        chk("clamp_lo_atspd", 32'(bus.at_speed), 0);
        tick();
        chk("clamp_lo_period", 32'(bus.step_period), 100);
        chk("clamp_lo_run",    32'(bus.state), 32'(RUN));

        // Stop from 100
        bus.run_req = 1'b0;
        cyc(1);
        chk("stop_state", 32'(bus.state), 32'(STOP));
        tick(); chk("stop_t1", 32'(bus.step_period), 400);
        tick(); chk("stop_t2", 32'(bus.step_period), 700);
        tick(); chk("stop_t3", 32'(bus.step_period), 1000);
        chk("stop_t3_state", 32'(bus.state), 32'(STOP));
        tick();
        chk("stop_idle",    32'(bus.state), 32'(IDLE));
        chk("stop_m3start", 32'(bus.m3start), 0);
        chk("stop_cnt",     32'(bus.step_cnt), 8);
        tick();
        chk("idle_tick_cnt",    32'(bus.step_cnt), 8);
        chk("idle_tick_period", 32'(bus.step_period), 1000);

        // Clamp high: target 5000 -> stays 1000, RUN
        bus.target_period = 25'd5000;
        bus.run_req = 1'b1;
        cyc(1);
        chk("clamp_hi_cnt0", 32'(bus.step_cnt), 0);
        tick();
        chk("clamp_hi_period", 32'(bus.step_period), 1000);
        chk("clamp_hi_run",    32'(bus.state), 32'(RUN));

        // Back to 200, then retarget to 800
        bus.target_period = 25'd200;
        tick(); tick(); tick();
        chk("re200_period", 32'(bus.step_period), 200);
        chk("re200_run",    32'(bus.state), 32'(RUN));
        bus.target_period = 25'd800;
        cyc(1);
        chk("re800_slew", 32'(bus.state), 32'(SLEW));
        tick(); chk("re800_t1", 32'(bus.step_period), 500);
        tick(); chk("re800_t2", 32'(bus.step_period), 800);
        chk("re800_run", 32'(bus.state), 32'(RUN));

        // run_req 0->1 during STOP resumes slewing from current period
        bus.run_req = 1'b0;
        cyc(1);
        chk("toggle_stop", 32'(bus.state), 32'(STOP));
        bus.target_period = 25'd200;
        bus.run_req = 1'b1;
        cyc(1);
        chk("toggle_slew",   32'(bus.state), 32'(SLEW));
        chk("toggle_period", 32'(bus.step_period), 800);
        tick(); chk("toggle_t1", 32'(bus.step_period), 500);
        tick(); chk("toggle_t2", 32'(bus.step_period), 200);
        chk("toggle_run", 32'(bus.state), 32'(RUN));

        // Tick coinciding with run_req fall in RUN: stop wins, period holds
        cyc(49);
        bus.run_req   = 1'b0;
        bus.step_tick = 1'b1;
        cyc(1);
        bus.step_tick = 1'b0;
        chk("simul_state",  32'(bus.state), 32'(STOP));
        chk("simul_period", 32'(bus.step_period), 200);

        // Fault mid-SLEW
        bus.run_req = 1'b1;
        bus.target_period = 25'd800;
        cyc(1);
        chk("flt_pre_slew", 32'(bus.state), 32'(SLEW));
        bus.fault_in = 1'b1;
        cyc(1);
        bus.fault_in = 1'b0;
        chk("flt_state",   32'(bus.state), 32'(FAULT));
        chk("flt_m3start", 32'(bus.m3start), 0);
        chk("flt_flag",    32'(bus.fault), 1);
        chk("flt_period",  32'(bus.step_period), 1000);
        bus.fault_clr = 1'b1;
        cyc(1);
        bus.fault_clr = 1'b0;
        chk("flt_clr_ign_state", 32'(bus.state), 32'(FAULT));
        chk("flt_clr_ign_flag",  32'(bus.fault), 1);
        bus.run_req = 1'b0;
        cyc(1);
        chk("flt_hold_noclr", 32'(bus.state), 32'(FAULT));
        bus.fault_clr = 1'b1;
        cyc(1);
        bus.fault_clr = 1'b0;
        chk("flt_clr_state", 32'(bus.state), 32'(IDLE));
        chk("flt_clr_flag",  32'(bus.fault), 0);

        // Asynchronous reset mid-run
        bus.target_period = 25'd200;
        bus.run_req = 1'b1;
        tick();
        chk("arst_pre_period", 32'(bus.step_period), 700);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_m3start", 32'(bus.m3start), 0);
        chk("arst_state",   32'(bus.state), 32'(IDLE));
        chk("arst_period",  32'(bus.step_period), 1000);
        chk("arst_cnt",     32'(bus.step_cnt), 0);
        cyc(1);
        rst = 1'b0;

        // Stall: no ticks for well over 500 cycles after start
        cyc(1);
        chk("wdog_start", 32'(bus.state), 32'(SLEW));
        cyc(520);
`ifdef MOTORO3_RAMP_WATCHDOG_EN
        chk("wdog_state", 32'(bus.state), 32'(FAULT));
        chk("wdog_flag",  32'(bus.fault), 1);
        chk("wdog_m3start", 32'(bus.m3start), 0);
`else
        chk("wdog_state", 32'(bus.state), 32'(SLEW));
        chk("wdog_flag",  32'(bus.fault), 0);
        chk("wdog_m3start", 32'(bus.m3start), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motoro3_ramp_scheduler.md
# motoro3_ramp_scheduler

Open-loop speed-ramp controller for the 3-phase commutation step generator. It starts the generator and supplies a per-step reload period. On each commutation step it slews that period toward a commanded target, then ramps down to a safe stop period before releasing the generator. It sits between the host command registers and the step generator, and owns start, stop and fault sequencing.

## Interface
- PW, 25, width of all period values (clk cycles per commutation step)
- START_PERIOD, 1_666_667, period at start and at stop; slowest allowed period
- MIN_PERIOD, 16_667, fastest allowed period
- STEP_DELTA, 16_667, maximum period change per commutation step
- WDOG_CYCLES, 4_000_000, watchdog limit; used only with the watchdog macro
- clk  in  1  system clock, 10 MHz; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- run_req  in  1  level; 1 = run, 0 = stop
- target_period  in  PW  commanded period; clamped to [MIN_PERIOD, START_PERIOD]
- step_tick  in  1  one-cycle pulse from the step generator on each commutation advance
- fault_in  in  1  external fault (overcurrent etc.), level
- fault_clr  in  1  one-cycle pulse; clears a latched fault
- m3start  out  1  run enable to the step generator
- step_period  out  PW  reload period to the step generator
- state  out  3  current FSM state (encoding in package)
- at_speed  out  1  1 while in RUN
- fault  out  1  latched fault flag
- step_cnt  out  16  commutation steps since start; wraps at 0xFFFF→0

## Operation
- Reset values: state=IDLE, m3start=0, step_period=START_PERIOD, at_speed=0, fault=0, step_cnt=0.
- tgt = clamp(target_period). The clamp is combinational and sampled every cycle.
- IDLE: if run_req=1 → SLEW. Set m3start=1, step_period=START_PERIOD, step_cnt=0.
- SLEW, on step_tick:
  - if step_period>tgt: period = max(step_period−STEP_DELTA, tgt)
  - if step_period<tgt: period = min(step_period+STEP_DELTA, tgt)
  - Compare in PW+1 bits so the subtraction cannot underflow.
  - When the new period equals tgt → RUN.
- RUN: at_speed=1. If tgt≠step_period → SLEW. step_period changes only on step_tick.
- run_req=0 in SLEW or RUN → STOP.
- STOP, on step_tick: period = min(step_period+STEP_DELTA, START_PERIOD).
  - On a step_tick when step_period already equals START_PERIOD → IDLE and m3start=0.
  - If run_req=1 in STOP → SLEW from the current period.
- step_cnt increments on every step_tick while m3start=1.
- Fault handling:
  - fault_in=1 in any state except IDLE → FAULT, m3start=0, fault=1, step_period=START_PERIOD.
  - Fault has priority over every other event in the same cycle.
- FAULT: leave to IDLE only when fault_clr=1 and run_req=0 in the same cycle, which clears fault. A fault_clr while run_req=1 is ignored.
- step_tick while in IDLE or FAULT is ignored.

## Timing
- All outputs are registered and update on the clk edge after the causing input.
- run_req rising in IDLE: m3start=1 one cycle later.
- step_tick: the new step_period is visible one cycle later, before the generator's next reload.
- fault_in: m3start falls one cycle later.
- Simultaneous step_tick and run_req fall in RUN: apply the stop decision; this tick is not a STOP increment.
- Reset mid-run: asynchronous return to the reset values, with m3start=0 immediately.

## Configuration
- MOTORO3_RAMP_WATCHDOG_EN defined:
  - A cycle counter clears on step_tick or when m3start=0.
  - When the counter reaches WDOG_CYCLES with m3start=1 → FAULT. This is a stalled-generator fault.
- Macro not defined: no counter; FAULT is entered only from fault_in.

## Structure
- Package motoro3_pkg holds:
  - the state enum: IDLE=0, SLEW=1, RUN=2, STOP=3, FAULT=4
  - the PW constant
  - a clamp function
- One sub-module, motoro3_step_watchdog (counter plus timeout pulse). It is instantiated only under MOTORO3_RAMP_WATCHDOG_EN.

## Test plan
Bench parameters: START=1000, MIN=100, DELTA=300.
- Start ramp: run_req=1, target=200, tick every 50 clk → step_period 1000, 700, 400, 200; RUN and at_speed=1 after the third tick.
- Clamp: target=10 → ramp ends at step_period=100; target=5000 → step_period stays 1000, RUN.
- Stop from 100: run_req=0 → period 400, 700, 1000 on ticks; next tick → IDLE, m3start=0; step_cnt holds.
- Fault mid-SLEW: fault_in=1 → next cycle FAULT, m3start=0, fault=1. fault_clr with run_req=1 is ignored; with run_req=0 → IDLE.
- Retarget in RUN at 200, target=800 → 500, 800, RUN. run_req toggled 0→1 during STOP → SLEW from the current period.
- Watchdog (macro on, WDOG_CYCLES=500): no step_tick for 500 clk after start → FAULT. Macro off: same stimulus stays in SLEW.
